// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-word block fill,
// per-set round-robin replacement, whole-cache flush and hit/miss counters.
module icache_sa #(
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int WB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TB = 30 - WB - IB;
  localparam int PB = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CB = (WB > 0) ? WB : 1;

  typedef enum logic {CHECK, FILL} state_t;

  state_t state;

  logic [31:0]   data_arr [SETS][WAYS][BLOCK_WORDS];
  logic [TB-1:0] tag_arr  [SETS][WAYS];
  logic [WAYS-1:0] valid  [SETS];
  logic [PB-1:0] ptr      [SETS];

  logic [TB-1:0] tag;
  logic [IB-1:0] idx;
  logic [CB-1:0] wofs;

  logic [TB-1:0] ltag;
  logic [IB-1:0] lidx;
  logic [PB-1:0] lway;
  logic          lptr;
  logic [CB-1:0] cnt;
  logic          flush_pend;

  logic          hit;
  logic [PB-1:0] hway;
  logic          inv;
  logic [PB-1:0] vic;
  logic          wr;
  logic          last;
  logic          clr;

  assign idx  = IB'(imemaddr >> (2 + WB));
  assign tag  = TB'(imemaddr >> (2 + WB + IB));
  assign wofs = CB'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));

  always_comb begin
    hit  = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tag_arr[idx][w] == tag) begin
        hit  = 1'b1;
        hway = PB'(w);
      end
    end
  end

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    inv = 1'b0;
    vic = ptr[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[idx][w]) begin
        inv = 1'b1;
        vic = PB'(w);
      end
    end
  end

  assign ihit = ~RST & (state == CHECK) & imemREN & hit & ~iflush;
  assign imemload = ihit ? data_arr[idx][hway][wofs] : '0;

  assign iREN = (state == FILL);
  assign iaddr = iREN ? ((32'(ltag) << (2 + WB + IB))
                       | (32'(lidx) << (2 + WB))
                       | (32'(cnt) << 2)) : '0;

  assign wr   = (state == FILL) && !iwait;
  assign last = (cnt == CB'(BLOCK_WORDS - 1));
  assign clr  = ((state == CHECK) && iflush)
              || (wr && last && (flush_pend || iflush));

  always_ff @(posedge CLK) begin
    if (wr) begin
      data_arr[lidx][lway][cnt] <= iload;
      if (last) tag_arr[lidx][lway] <= ltag;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= CHECK;
      cnt        <= '0;
      flush_pend <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      ltag       <= '0;
      lidx       <= '0;
      lway       <= '0;
      lptr       <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        ptr[s]   <= '0;
      end
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      unique case (state)
        CHECK: begin
          if (!iflush && imemREN && !hit) begin
            ltag       <= tag;
            lidx       <= idx;
            lway       <= vic;
            lptr       <= !inv;
            cnt        <= '0;
            miss_count <= miss_count + 32'd1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (iflush) flush_pend <= 1'b1;
          if (!iwait) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              cnt        <= '0;
              state      <= CHECK;
              flush_pend <= 1'b0;
              valid[lidx][lway] <= 1'b1;
              if (lptr && WAYS > 1) ptr[lidx] <= ptr[lidx] + 1'b1;
            end
          end
        end
      endcase
      // Flush overrides any valid/pointer update made above.
      if (clr) begin
        for (int s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          ptr[s]   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa at default parameters.
// Memory returns {16'hC0DE, iaddr[15:0]} for every read.
module tb_icache_sa;

  localparam int BW = 2;

  logic        clk = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  always #5 clk = ~clk;

  assign iload = {16'hC0DE, iaddr[15:0]};

  icache_sa dut (
    .CLK        (clk),
    .RST        (RST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .iflush     (iflush),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iload      (iload),
    .iwait      (iwait),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  task automatic check(input string t, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    RST      = 1'b1;
    imemREN  = 1'b0;
    imemaddr = '0;
    iflush   = 1'b0;
    iwait    = 1'b0;
    tick;
    tick;
    RST = 1'b0;
  endtask

  task automatic probe(input string t, input logic [31:0] a,
                       input bit h, input logic [31:0] d);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
    check({t, "_hit"}, 32'(ihit), 32'(h));
    if (h) check({t, "_data"}, imemload, d);
    tick;
    imemREN = 1'b0;
    if (!h) begin
      check({t, "_fill"}, 32'(iREN), 32'd1);
      repeat (BW) tick;
    end
  endtask

  initial begin
    do_reset;
    check("rst_ihit", 32'(ihit), 0);
    check("rst_load", imemload, 0);
    check("rst_iren", 32'(iREN), 0);
    check("rst_iaddr", iaddr, 0);
    check("rst_hits", hit_count, 0);
    check("rst_miss", miss_count, 0);

    // cold miss and fill
    imemREN  = 1'b1;
    imemaddr = 32'h000;
    #1;
    check("c0_ihit", 32'(ihit), 0);
    tick;
    check("c1_iren", 32'(iREN), 1);
    check("c1_iaddr", iaddr, 32'h000);
    check("c1_ihit", 32'(ihit), 0);
    tick;
    check("c2_iren", 32'(iREN), 1);
    check("c2_iaddr", iaddr, 32'h004);
    tick;
    check("c3_iren", 32'(iREN), 0);
    check("c3_ihit", 32'(ihit), 1);
    check("c3_data", imemload, 32'hC0DE0000);
    check("c3_miss", miss_count, 1);
    tick;
    imemaddr = 32'h004;
    #1;
    check("c4_ihit", 32'(ihit), 1);
    check("c4_data", imemload, 32'hC0DE0004);
    tick;
    imemREN = 1'b0;
    check("c5_hits", hit_count, 2);
    check("c5_miss", miss_count, 1);

    // round-robin replacement in set 0
    probe("r040a", 32'h040, 0, 0);
    probe("r080a", 32'h080, 0, 0);
    probe("r040b", 32'h040, 1, 32'hC0DE0040);
    probe("r000a", 32'h000, 0, 0);
    probe("r080b", 32'h080, 1, 32'hC0DE0080);
    probe("r040c", 32'h040, 0, 0);
    probe("r000b", 32'h000, 1, 32'hC0DE0000);
    check("r_hits", hit_count, 5);
    check("r_miss", miss_count, 5);

    // stall with redirect during fill
    do_reset;
    imemREN  = 1'b1;
    imemaddr = 32'h000;
    tick;
    cyc = 1;
    for (int w = 0; w < BW; w++) begin
      for (int s = 0; s < 4; s++) begin
        iwait = (s < 3);
        if (cyc == 2) imemaddr = 32'h100;
        #1;
        check($sformatf("st_iaddr_%0d", cyc), iaddr, 32'(w * 4));
        check($sformatf("st_iren_%0d", cyc), 32'(iREN), 1);
        tick;
        cyc++;
      end
    end
    iwait = 1'b0;
    #1;
    check("st_redir_ihit", 32'(ihit), 0);
    check("st_redir_iren", 32'(iREN), 0);
    tick;
    check("st_redir_iaddr", iaddr, 32'h100);
    imemREN = 1'b0;
    repeat (BW) tick;
    probe("st_w0", 32'h000, 1, 32'hC0DE0000);
    probe("st_w1", 32'h004, 1, 32'hC0DE0004);
    check("st_hits", hit_count, 2);
    check("st_miss", miss_count, 2);

    // flush in CHECK
    imemREN  = 1'b1;
    imemaddr = 32'h000;
    iflush   = 1'b1;
    #1;
    check("fl_ihit", 32'(ihit), 0);
    tick;
    iflush  = 1'b0;
    imemREN = 1'b0;
    check("fl_nomiss", 32'(iREN), 0);
    probe("fl_000a", 32'h000, 0, 0);

    // flush during a fill
    imemREN  = 1'b1;
    imemaddr = 32'h100;
    #1;
    check("ff_ihit", 32'(ihit), 0);
    tick;
    imemREN = 1'b0;
    iflush  = 1'b1;
    check("ff_iaddr0", iaddr, 32'h100);
    tick;
    iflush = 1'b0;
    check("ff_iaddr1", iaddr, 32'h104);
    tick;
    check("ff_done", 32'(iREN), 0);
    probe("ff_000", 32'h000, 0, 0);
    probe("ff_100", 32'h100, 0, 0);

    // reset mid-fill
    imemREN  = 1'b1;
    imemaddr = 32'h200;
    tick;
    RST = 1'b1;
    check("rm_iren_pre", 32'(iREN), 1);
    tick;
    RST     = 1'b0;
    imemREN = 1'b0;
    check("rm_iren", 32'(iREN), 0);
    check("rm_iaddr", iaddr, 0);
    check("rm_hits", hit_count, 0);
    check("rm_miss", miss_count, 0);
    probe("rm_000", 32'h000, 0, 0);
    check("rm_miss1", miss_count, 1);

    // idle fetch to an uncached address
    imemREN  = 1'b0;
    imemaddr = 32'h300;
    #1;
    check("id_ihit", 32'(ihit), 0);
    check("id_load", imemload, 0);
    tick;
    check("id_iren", 32'(iREN), 0);
    check("id_hits", hit_count, 0);
    check("id_miss", miss_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
